// File: rtl/aq_pmp_chk_arb_if.sv
// aq_pmp_chk_arb_if: requester, CSR-fence and PMP check-port signals of the PMP check arbiter
interface aq_pmp_chk_arb_if #(parameter int PA_W = 28);
    logic            ifu_pmp_req_vld;
    logic [PA_W-1:0] ifu_pmp_req_pa;
    logic [1:0]      ifu_pmp_req_priv;
    logic            ifu_pmp_req_rdy;
    logic            lsu_pmp_req_vld;
    logic [PA_W-1:0] lsu_pmp_req_pa;
    logic [1:0]      lsu_pmp_req_priv;
    logic            lsu_pmp_req_chk1;
    logic            lsu_pmp_req_rdy;
    logic            cp0_pmp_wreg;
    logic [PA_W-1:0] arb_pmp_pa;
    logic [1:0]      arb_pmp_priv_mode;
    logic            arb_pmp_chk1;
    logic [3:0]      pmp_arb_flg;
    logic [15:0]     pmp_arb_hit_num;
    logic            pmp_arb_napot_cross;
    logic            ifu_pmp_rsp_vld;
    logic            lsu_pmp_rsp_vld;
    logic [3:0]      pmp_rsp_flg;
    logic [15:0]     pmp_rsp_hit_num;
    logic            pmp_rsp_napot_cross;
    logic            arb_pmp_busy;
    modport slave (
        input  ifu_pmp_req_vld, ifu_pmp_req_pa, ifu_pmp_req_priv,
        input  lsu_pmp_req_vld, lsu_pmp_req_pa, lsu_pmp_req_priv, lsu_pmp_req_chk1,
        input  cp0_pmp_wreg, pmp_arb_flg, pmp_arb_hit_num, pmp_arb_napot_cross,
        output ifu_pmp_req_rdy, lsu_pmp_req_rdy,
        output arb_pmp_pa, arb_pmp_priv_mode, arb_pmp_chk1,
        output ifu_pmp_rsp_vld, lsu_pmp_rsp_vld,
        output pmp_rsp_flg, pmp_rsp_hit_num, pmp_rsp_napot_cross, arb_pmp_busy
    );
    modport master (
        output ifu_pmp_req_vld, ifu_pmp_req_pa, ifu_pmp_req_priv,
        output lsu_pmp_req_vld, lsu_pmp_req_pa, lsu_pmp_req_priv, lsu_pmp_req_chk1,
        output cp0_pmp_wreg, pmp_arb_flg, pmp_arb_hit_num, pmp_arb_napot_cross,
        input  ifu_pmp_req_rdy, lsu_pmp_req_rdy,
        input  arb_pmp_pa, arb_pmp_priv_mode, arb_pmp_chk1,
        input  ifu_pmp_rsp_vld, lsu_pmp_rsp_vld,
        input  pmp_rsp_flg, pmp_rsp_hit_num, pmp_rsp_napot_cross, arb_pmp_busy
    );
endinterface

// File: rtl/aq_pmp_chk_arb.sv
// aq_pmp_chk_arb: round-robin IFU/LSU arbiter and two-cycle sequencer for the shared PMP check port
module aq_pmp_chk_arb (
    input logic               cpuclk,
    input logic               cpurst,
    aq_pmp_chk_arb_if.slave   bus
);
    typedef enum logic {IDLE, CHK} state_t;
    state_t state;
    logic   wreg_d, rr, owner, win, ifu_win, lsu_win;
    // CSR writes fence grants for their own cycle and the one after
    always_comb begin
        win     = state == IDLE && !(bus.cp0_pmp_wreg || wreg_d) && !cpurst;
        ifu_win = bus.ifu_pmp_req_vld && (!bus.lsu_pmp_req_vld || rr);
        lsu_win = bus.lsu_pmp_req_vld && (!bus.ifu_pmp_req_vld || !rr);
    end
    assign bus.ifu_pmp_req_rdy = win && ifu_win;
    assign bus.lsu_pmp_req_rdy = win && lsu_win;
    assign bus.arb_pmp_busy    = state == CHK || bus.cp0_pmp_wreg || wreg_d;
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            state                   <= IDLE;
            wreg_d                  <= 1'b0;
            rr                      <= 1'b0;
            owner                   <= 1'b0;
            bus.arb_pmp_pa          <= '0;
            bus.arb_pmp_priv_mode   <= '0;
            bus.arb_pmp_chk1        <= 1'b0;
            bus.ifu_pmp_rsp_vld     <= 1'b0;
            bus.lsu_pmp_rsp_vld     <= 1'b0;
            bus.pmp_rsp_flg         <= '0;
            bus.pmp_rsp_hit_num     <= '0;
            bus.pmp_rsp_napot_cross <= 1'b0;
        end else begin
            wreg_d              <= bus.cp0_pmp_wreg;
            bus.ifu_pmp_rsp_vld <= state == CHK && !owner;
            bus.lsu_pmp_rsp_vld <= state == CHK && owner;
            if (state == CHK) begin
                state                   <= IDLE;
                bus.pmp_rsp_flg         <= bus.pmp_arb_flg;
                bus.pmp_rsp_hit_num     <= bus.pmp_arb_hit_num;
                bus.pmp_rsp_napot_cross <= bus.pmp_arb_napot_cross;
            end else if (bus.ifu_pmp_req_rdy || bus.lsu_pmp_req_rdy) begin
                state                 <= CHK;
                owner                 <= bus.lsu_pmp_req_rdy;
                rr                    <= bus.lsu_pmp_req_rdy;
                bus.arb_pmp_pa        <= bus.lsu_pmp_req_rdy ? bus.lsu_pmp_req_pa : bus.ifu_pmp_req_pa;
                bus.arb_pmp_priv_mode <= bus.lsu_pmp_req_rdy ? bus.lsu_pmp_req_priv : bus.ifu_pmp_req_priv;
                bus.arb_pmp_chk1      <= bus.lsu_pmp_req_rdy && bus.lsu_pmp_req_chk1;
            end
        end
    end
endmodule

// File: tb/tb_aq_pmp_chk_arb.sv
// tb_aq_pmp_chk_arb: directed vectors with a response scoreboard for the PMP check arbiter
module tb_aq_pmp_chk_arb;
    logic cpuclk = 1'b0;
    logic cpurst = 1'b1;
    int   nvec = 0;
    int   nfail = 0;
    logic [22:0] exp_q[$];

    aq_pmp_chk_arb_if #(.PA_W(28)) bus ();
    aq_pmp_chk_arb dut (.cpuclk(cpuclk), .cpurst(cpurst), .bus(bus));

    always #5 cpuclk = ~cpuclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic lsu, input logic [3:0] flg, input logic [15:0] hit, input logic nc);
        exp_q.push_back({lsu, !lsu, flg, hit, nc});
    endtask

    task automatic pmp(input logic [3:0] flg, input logic [15:0] hit, input logic nc);
        bus.pmp_arb_flg = flg;
        bus.pmp_arb_hit_num = hit;
        bus.pmp_arb_napot_cross = nc;
    endtask

    // response monitor: {lsu_vld, ifu_vld, flg, hit, napot} against the queue head
    always @(negedge cpuclk) begin
        if (bus.ifu_pmp_rsp_vld || bus.lsu_pmp_rsp_vld) begin
            if (exp_q.size() == 0)
                chk("unexpected_rsp", {bus.lsu_pmp_rsp_vld, bus.ifu_pmp_rsp_vld}, 32'h0);
            else
                chk("rsp", {bus.lsu_pmp_rsp_vld, bus.ifu_pmp_rsp_vld, bus.pmp_rsp_flg,
                            bus.pmp_rsp_hit_num, bus.pmp_rsp_napot_cross}, {9'h0, exp_q.pop_front()});
        end
    end

    initial begin
        bus.ifu_pmp_req_vld = 1'b1;
        bus.ifu_pmp_req_pa = 28'h0;
        bus.ifu_pmp_req_priv = 2'b00;
        bus.lsu_pmp_req_vld = 1'b1;
        bus.lsu_pmp_req_pa = 28'h0;
        bus.lsu_pmp_req_priv = 2'b00;
        bus.lsu_pmp_req_chk1 = 1'b0;
        bus.cp0_pmp_wreg = 1'b0;
        pmp(4'h0, 16'h0, 1'b0);
        // reset state, requests pending throughout
        step();
        step();
        settle();
        chk("rst_ifu_rdy", bus.ifu_pmp_req_rdy, 0);
        chk("rst_lsu_rdy", bus.lsu_pmp_req_rdy, 0);
        chk("rst_outputs", {bus.arb_pmp_pa, bus.arb_pmp_priv_mode, bus.arb_pmp_chk1,
                            bus.ifu_pmp_rsp_vld, bus.lsu_pmp_rsp_vld, bus.arb_pmp_busy}, 0);
        chk("rst_rsp_data", {bus.pmp_rsp_flg, bus.pmp_rsp_hit_num, bus.pmp_rsp_napot_cross}, 0);
        cpurst = 1'b0;
        bus.ifu_pmp_req_vld = 1'b0;
        bus.lsu_pmp_req_vld = 1'b0;

        // single IFU request
        step();
        bus.ifu_pmp_req_vld = 1'b1;
        bus.ifu_pmp_req_pa = 28'h0000123;
        bus.ifu_pmp_req_priv = 2'b00;
        pmp(4'b0101, 16'h0004, 1'b0);
        settle();
        chk("t1_ifu_rdy", bus.ifu_pmp_req_rdy, 1);
        chk("t1_lsu_rdy", bus.lsu_pmp_req_rdy, 0);
        push(1'b0, 4'b0101, 16'h0004, 1'b0);
        step();
        bus.ifu_pmp_req_vld = 1'b0;
        settle();
        chk("t1_arb_pa", bus.arb_pmp_pa, 28'h0000123);
        chk("t1_arb_chk1", bus.arb_pmp_chk1, 0);
        chk("t1_busy_chk", bus.arb_pmp_busy, 1);
        step();
        pmp(4'hF, 16'hFFFF, 1'b1);
        settle();
        chk("t1_busy_idle", bus.arb_pmp_busy, 0);
        step();

        // both requesters continuously valid from reset: LSU, IFU, LSU, IFU
        cpurst = 1'b1;
        step();
        cpurst = 1'b0;
        bus.ifu_pmp_req_vld = 1'b1;
        bus.ifu_pmp_req_pa = 28'h0000AAA;
        bus.ifu_pmp_req_priv = 2'b01;
        bus.lsu_pmp_req_vld = 1'b1;
        bus.lsu_pmp_req_pa = 28'h0000555;
        bus.lsu_pmp_req_priv = 2'b11;
        bus.lsu_pmp_req_chk1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic lsu_turn;
            lsu_turn = (i % 2) == 0;
            pmp(4'(i + 1), 16'(1 << (i + 4)), 1'(i));
            settle();
            chk("t2_lsu_rdy", bus.lsu_pmp_req_rdy, {31'h0, lsu_turn});
            chk("t2_ifu_rdy", bus.ifu_pmp_req_rdy, {31'h0, !lsu_turn});
            push(lsu_turn, 4'(i + 1), 16'(1 << (i + 4)), 1'(i));
            step();
            settle();
            chk("t2_chk_no_rdy", {bus.lsu_pmp_req_rdy, bus.ifu_pmp_req_rdy}, 0);
            chk("t2_arb_pa", bus.arb_pmp_pa, lsu_turn ? 28'h0000555 : 28'h0000AAA);
            chk("t2_arb_chk1", bus.arb_pmp_chk1, {31'h0, lsu_turn});
            step();
        end
        bus.ifu_pmp_req_vld = 1'b0;
        bus.lsu_pmp_req_vld = 1'b0;

        // CSR write fence with LSU request raised in the same cycle
        step();
        bus.cp0_pmp_wreg = 1'b1;
        bus.lsu_pmp_req_vld = 1'b1;
        bus.lsu_pmp_req_pa = 28'h0ABCDEF;
        bus.lsu_pmp_req_priv = 2'b10;
        bus.lsu_pmp_req_chk1 = 1'b0;
        settle();
        chk("t3_w_rdy", bus.lsu_pmp_req_rdy, 0);
        chk("t3_w_busy", bus.arb_pmp_busy, 1);
        step();
        bus.cp0_pmp_wreg = 1'b0;
        settle();
        chk("t3_w1_rdy", bus.lsu_pmp_req_rdy, 0);
        chk("t3_w1_busy", bus.arb_pmp_busy, 1);
        step();
        pmp(4'h3, 16'h0100, 1'b0);
        settle();
        chk("t3_w2_rdy", bus.lsu_pmp_req_rdy, 1);
        push(1'b1, 4'h3, 16'h0100, 1'b0);
        step();
        bus.lsu_pmp_req_vld = 1'b0;
        settle();
        chk("t3_arb_priv", bus.arb_pmp_priv_mode, 2'b10);
        step();
        step();

        // CSR write during CHK: response uses CHK-cycle flags, then fence
        bus.ifu_pmp_req_vld = 1'b1;
        bus.ifu_pmp_req_pa = 28'h7654321;
        bus.ifu_pmp_req_priv = 2'b11;
        pmp(4'h9, 16'h0020, 1'b1);
        settle();
        chk("t4_ifu_rdy", bus.ifu_pmp_req_rdy, 1);
        push(1'b0, 4'h9, 16'h0020, 1'b1);
        step();
        bus.ifu_pmp_req_vld = 1'b0;
        bus.cp0_pmp_wreg = 1'b1;
        bus.lsu_pmp_req_vld = 1'b1;
        bus.lsu_pmp_req_pa = 28'h1111111;
        bus.lsu_pmp_req_priv = 2'b01;
        bus.lsu_pmp_req_chk1 = 1'b1;
        settle();
        chk("t4_chk_rdy", bus.lsu_pmp_req_rdy, 0);
        step();
        bus.cp0_pmp_wreg = 1'b0;
        pmp(4'h6, 16'h4000, 1'b0);
        settle();
        chk("t4_fence_rdy", bus.lsu_pmp_req_rdy, 0);
        chk("t4_fence_busy", bus.arb_pmp_busy, 1);
        step();
        settle();
        chk("t4_post_rdy", bus.lsu_pmp_req_rdy, 1);
        push(1'b1, 4'h6, 16'h4000, 1'b0);
        step();
        bus.lsu_pmp_req_vld = 1'b0;
        settle();
        chk("t4_arb_chk1", bus.arb_pmp_chk1, 1);
        step();
        step();

        // reset during CHK drops the check and clears rr
        bus.ifu_pmp_req_vld = 1'b1;
        bus.ifu_pmp_req_pa = 28'h2222222;
        bus.lsu_pmp_req_vld = 1'b1;
        bus.lsu_pmp_req_pa = 28'h3333333;
        bus.lsu_pmp_req_priv = 2'b00;
        bus.lsu_pmp_req_chk1 = 1'b0;
        pmp(4'hC, 16'h0800, 1'b1);
        settle();
        chk("t5_ifu_pref", {bus.lsu_pmp_req_rdy, bus.ifu_pmp_req_rdy}, 2'b01);
        step();
        cpurst = 1'b1;
        settle();
        chk("t5_rst_rdy", {bus.lsu_pmp_req_rdy, bus.ifu_pmp_req_rdy}, 0);
        step();
        cpurst = 1'b0;
        pmp(4'hE, 16'h0002, 1'b0);
        settle();
        chk("t5_outputs", {bus.arb_pmp_pa, bus.arb_pmp_priv_mode, bus.arb_pmp_chk1,
                           bus.ifu_pmp_rsp_vld, bus.lsu_pmp_rsp_vld, bus.arb_pmp_busy}, 0);
        chk("t5_rsp_data", {bus.pmp_rsp_flg, bus.pmp_rsp_hit_num, bus.pmp_rsp_napot_cross}, 0);
        chk("t5_lsu_pref", {bus.lsu_pmp_req_rdy, bus.ifu_pmp_req_rdy}, 2'b10);
        push(1'b1, 4'hE, 16'h0002, 1'b0);
        step();
        bus.ifu_pmp_req_vld = 1'b0;
        bus.lsu_pmp_req_vld = 1'b0;
        settle();
        chk("t5_arb_pa", bus.arb_pmp_pa, 28'h3333333);
        step();
        step();

        // LSU chk1 with machine privilege and NAPOT crossing
        bus.lsu_pmp_req_vld = 1'b1;
        bus.lsu_pmp_req_pa = 28'hFEDCBA9;
        bus.lsu_pmp_req_priv = 2'b11;
        bus.lsu_pmp_req_chk1 = 1'b1;
        pmp(4'hA, 16'h8000, 1'b1);
        settle();
        chk("t6_lsu_rdy", bus.lsu_pmp_req_rdy, 1);
        push(1'b1, 4'hA, 16'h8000, 1'b1);
        step();
        bus.lsu_pmp_req_vld = 1'b0;
        settle();
        chk("t6_arb", {bus.arb_pmp_pa, bus.arb_pmp_priv_mode, bus.arb_pmp_chk1}, {1'b0, 28'hFEDCBA9, 2'b11, 1'b1});
        step();
        step();
        step();
        settle();
        chk("pending_rsp", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/aq_pmp_chk_arb.md
# aq_pmp_chk_arb

Arbiter and sequencer for the single PMP access-check port. It shares the check port between the instruction-fetch requester (IFU) and the load/store requester (LSU). Each accepted request is registered and presented to the PMP check logic for one cycle, and the result goes back to the winning requester as a one-cycle response. Grants are held off while a PMP CSR write is in progress and for one cycle after it, so that no check mixes old and new configuration.

## Interface
Parameters:
- PA_W, 28, physical-address bits driven to the PMP check port.

Ports:
- cpuclk  input  1  clock; all state updates on the rising edge.
- cpurst  input  1  reset; synchronous, active-high.
- ifu_pmp_req_vld  input  1  IFU check request; held with its payload until accepted.
- ifu_pmp_req_pa  input  PA_W  IFU physical address.
- ifu_pmp_req_priv  input  2  IFU privilege mode.
- ifu_pmp_req_rdy  output  1  IFU request accepted this cycle when high together with ifu_pmp_req_vld.
- lsu_pmp_req_vld  input  1  LSU check request; held with its payload until accepted.
- lsu_pmp_req_pa  input  PA_W  LSU physical address.
- lsu_pmp_req_priv  input  2  LSU privilege mode.
- lsu_pmp_req_chk1  input  1  LSU second-check select.
- lsu_pmp_req_rdy  output  1  LSU request accepted this cycle when high together with lsu_pmp_req_vld.
- cp0_pmp_wreg  input  1  PMP CSR write in progress this cycle.
- arb_pmp_pa  output  PA_W  address to the PMP check port.
- arb_pmp_priv_mode  output  2  privilege mode to the PMP check port.
- arb_pmp_chk1  output  1  chk1 to the PMP check port.
- pmp_arb_flg  input  4  combinational check result flags.
- pmp_arb_hit_num  input  16  one-hot matching-entry vector.
- pmp_arb_napot_cross  input  1  NAPOT-crossing indication.
- ifu_pmp_rsp_vld  output  1  response for IFU; one-cycle pulse.
- lsu_pmp_rsp_vld  output  1  response for LSU; one-cycle pulse.
- pmp_rsp_flg  output  4  registered flags, shared by both requesters.
- pmp_rsp_hit_num  output  16  registered hit vector, shared.
- pmp_rsp_napot_cross  output  1  registered NAPOT-cross bit, shared.
- arb_pmp_busy  output  1  high while the FSM is not IDLE or the fence is active.

## Operation
- FSM states: IDLE and CHK.
- IDLE → CHK on any accepted request.
- CHK → IDLE unconditionally after one cycle.
- Fence: wreg_d is a register holding cp0_pmp_wreg delayed by one cycle. fence = cp0_pmp_wreg | wreg_d.
- Grant window: a grant occurs only when state==IDLE, fence==0 and cpurst==0.
- Arbitration is round-robin, with a 1-bit pointer rr (0 = LSU preferred, 1 = IFU preferred).
  - Single requester: that requester wins.
  - Both requesting: the preferred requester wins.
  - rr updates on every grant: it becomes 1 after an LSU grant and 0 after an IFU grant.
- ready outputs are combinational: xxx_req_rdy = grant-window & (this requester wins). Both ready outputs are never high together.
- On grant:
  - req_pa, req_priv and req_chk1 are registered. IFU chk1 is forced to 0.
  - owner is registered (0 = IFU, 1 = LSU).
  - arb_pmp_* are driven directly from these registers and are stable through CHK.
- At the end of CHK:
  - pmp_arb_flg, pmp_arb_hit_num and pmp_arb_napot_cross are registered into pmp_rsp_*.
  - The rsp_vld selected by owner is set for one cycle.
- pmp_rsp_* hold their value until the next response.
- A CSR write asserted during CHK does not abort the check. The response reflects the configuration in effect during CHK, i.e. the pre-write values.

## Timing
- Reset values (after the first edge with cpurst=1):
  - state=IDLE, rr=0, wreg_d=0, owner=0.
  - arb_pmp_pa=0, arb_pmp_priv_mode=0, arb_pmp_chk1=0.
  - All rsp_vld=0, pmp_rsp_*=0, arb_pmp_busy=0.
  - Both ready outputs are 0 while cpurst=1.
- Latency: handshake in cycle N → arb_pmp_* valid in cycle N+1 (CHK) → rsp_vld and data in cycle N+2.
- Throughput: one check every 2 cycles. A new grant is allowed in cycle N+2, the same cycle as the previous response.
- Fence: cp0_pmp_wreg high in cycle W blocks grants in cycles W and W+1. The earliest grant is W+2.
- Reset mid-CHK: the in-flight check is dropped and no rsp_vld is produced.
- Requester rules:
  - A requester must not deassert vld or change payload before acceptance.
  - The block does not check this rule; a violation is undefined.

## Test plan
- Single IFU request, pa=28'h0000123, priv=2'b00, PMP returns flg=4'b0101 and hit=16'h0004:
  - ifu_req_rdy=1 in cycle N.
  - arb_pmp_pa=28'h0000123 and arb_pmp_chk1=0 in cycle N+1.
  - ifu_rsp_vld=1 with flg=4'b0101 and hit_num=16'h0004 in cycle N+2, for exactly one cycle.
- Both requesters continuously valid from reset: grant order LSU, IFU, LSU, IFU, with grants every 2 cycles and rsp_vld alternating lsu/ifu.
- cp0_pmp_wreg pulsed in cycle 10 while both requesters are idle and the LSU raises vld in cycle 10: lsu_req_rdy=0 in cycles 10–11 and 1 in cycle 12; response in cycle 14.
- cp0_pmp_wreg asserted during CHK: the response still arrives 2 cycles after the grant, with the flags sampled during CHK; no grant in the following 2 cycles.
- cpurst asserted in CHK cycle 5: no rsp_vld in cycle 6; all outputs at reset values; rr=0, so the next simultaneous request grants LSU.
- LSU request with chk1=1 and priv=2'b11: arb_pmp_chk1=1 and arb_pmp_priv_mode=2'b11 in CHK; pmp_arb_napot_cross=1 appears on pmp_rsp_napot_cross with lsu_rsp_vld.
